// File: rtl/pipelined_csel_adder_pkg.sv
// Package: pcsa_pkg
// Purpose: shared sizing helpers and saturation constants for the pipelined
//          carry-select adder/subtractor.
//   pcsa_nblk    : number of BLK-bit carry-select blocks in a WIDTH-bit word
//   pcsa_nstg    : number of pipeline stages (ceil(blocks / blocks-per-stage))
//   pcsa_sat_max : most positive signed WIDTH-bit value (0x7FF..F), LSB-aligned
//   pcsa_sat_min : most negative signed WIDTH-bit value (0x800..0), LSB-aligned
package pcsa_pkg;

    localparam int unsigned PCSA_MAX_W = 256;

    function automatic int unsigned pcsa_nblk(input int unsigned width,
                                              input int unsigned blk);
        return width / blk;
    endfunction

    function automatic int unsigned pcsa_nstg(input int unsigned width,
                                              input int unsigned blk,
                                              input int unsigned blks_per_stg);
        return (pcsa_nblk(width, blk) + blks_per_stg - 1) / blks_per_stg;
    endfunction

    function automatic logic [PCSA_MAX_W-1:0] pcsa_sat_max(input int unsigned width);
        logic [PCSA_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < PCSA_MAX_W; i++) begin
            if (i + 1 < width) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [PCSA_MAX_W-1:0] pcsa_sat_min(input int unsigned width);
        logic [PCSA_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < PCSA_MAX_W; i++) begin
            if (i + 1 == width) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipelined_csel_adder_csel_block.sv
// Module: csel_block
// Purpose: one BLK-bit carry-select block; computes the block sum for both
//          possible carry-ins so the real carry only has to drive a mux.
// Ports:
//   a, b   : BLK-bit operand slices
//   sum0   : a + b       (carry-in 0),  cout0 its carry-out
//   sum1   : a + b + 1   (carry-in 1),  cout1 its carry-out
module csel_block #(
    parameter int unsigned BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    output logic [BLK-1:0] sum0,
    output logic [BLK-1:0] sum1,
    output logic           cout0,
    output logic           cout1
);

    assign {cout0, sum0} = {1'b0, a} + {1'b0, b};
    assign {cout1, sum1} = {1'b0, a} + {1'b0, b} + (BLK+1)'(1);

endmodule

// File: rtl/pipelined_csel_adder.sv
// Module: pipelined_csel_adder
// Purpose: parametrised, pipelined carry-select adder/subtractor with
//          valid/ready flow control and c/v/z status flags. Each stage
//          resolves BLKS_PER_STG carry-select blocks; latency is NSTG cycles.
// Optional feature: define PCSA_SATURATE_EN to add the `sat` input, which
//          clamps an overflowing result to the signed max/min.
// Ports:
//   clock, reset_n       : clock (rising edge), async active-low reset
//   in_valid / in_ready  : operand beat handshake
//   sub, c_in, in1, in2  : operation select, add carry-in, operands
//   sat                  : (PCSA_SATURATE_EN only) saturate on overflow
//   out_valid / out_ready: result beat handshake
//   s, c, v, z           : result, carry-out (no-borrow in sub), overflow, zero
module pipelined_csel_adder
    import pcsa_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned BLK          = 4,
    parameter int unsigned BLKS_PER_STG = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             c_in,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
`ifdef PCSA_SATURATE_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             v,
    output logic             z
);

    localparam int unsigned NBLK = pcsa_nblk(WIDTH, BLK);
    localparam int unsigned NSTG = pcsa_nstg(WIDTH, BLK, BLKS_PER_STG);

`ifdef PCSA_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(pcsa_sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(pcsa_sat_min(WIDTH));
`endif

    // Stage registers: operands travel with the beat; r_q holds low bits resolved so far
    logic [WIDTH-1:0] a_q  [NSTG];
    logic [WIDTH-1:0] b_q  [NSTG];
    logic [WIDTH-1:0] r_q  [NSTG];
    logic             cy_q [NSTG];
    logic             vld_q[NSTG];
    logic             v_q;
    logic             z_q;

    // Inputs seen by each stage (stage 0 from the ports, others from the previous register)
    logic [WIDTH-1:0] a_in [NSTG];
    logic [WIDTH-1:0] b_in [NSTG];
    logic [WIDTH-1:0] r_in [NSTG];
    logic             cy_in[NSTG];

    logic [WIDTH-1:0] r_nxt [NSTG];
    logic             cy_nxt[NSTG];
    logic [WIDTH-1:0] s_fin;
    logic             v_nxt;
    logic             z_nxt;
    logic             a_top;
    logic             b_top;
    logic             carry;
    logic [WIDTH-1:0] res;
    logic             adv;

    logic [BLK-1:0]   sum0 [NBLK];
    logic [BLK-1:0]   sum1 [NBLK];
    logic             co0  [NBLK];
    logic             co1  [NBLK];

`ifdef PCSA_SATURATE_EN
    logic             sat_q [NSTG];
    logic             sat_in[NSTG];
`endif

    // Global stall: the whole pipe advances only when the output slot frees up
    assign adv       = out_ready || !vld_q[NSTG-1];
    assign in_ready  = adv;
    assign out_valid = vld_q[NSTG-1];
    assign s         = r_q[NSTG-1];
    assign c         = cy_q[NSTG-1];
    assign v         = v_q;
    assign z         = z_q;

    // Operand preparation and stage-input selection
    always_comb begin
        a_in[0]  = in1;
        b_in[0]  = sub ? ~in2 : in2;
        r_in[0]  = '0;
        cy_in[0] = sub ? 1'b1 : c_in;
        for (int unsigned k = 1; k < NSTG; k++) begin
            a_in[k]  = a_q[k-1];
            b_in[k]  = b_q[k-1];
            r_in[k]  = r_q[k-1];
            cy_in[k] = cy_q[k-1];
        end
    end

`ifdef PCSA_SATURATE_EN
    always_comb begin
        sat_in[0] = sat;
        for (int unsigned k = 1; k < NSTG; k++) begin
            sat_in[k] = sat_q[k-1];
        end
    end
`endif

    // Block sums: block 0 ripples with the real carry-in, the rest precompute both carries
    for (genvar j = 0; j < int'(NBLK); j++) begin : g_blk
        localparam int unsigned ST = int'(j) / BLKS_PER_STG;
        if (j == 0) begin : g_ripple
            assign {co0[j], sum0[j]} = {1'b0, a_in[0][BLK-1:0]} + {1'b0, b_in[0][BLK-1:0]}
                                     + (BLK+1)'(cy_in[0]);
            assign sum1[j] = sum0[j];
            assign co1[j]  = co0[j];
        end else begin : g_csel
            csel_block #(
                .BLK(BLK)
            ) u_blk (
                .a    (a_in[ST][j*BLK +: BLK]),
                .b    (b_in[ST][j*BLK +: BLK]),
                .sum0 (sum0[j]),
                .sum1 (sum1[j]),
                .cout0(co0[j]),
                .cout1(co1[j])
            );
        end
    end

    // Carry-select resolution: each stage muxes its own blocks with the rippling select carry
    always_comb begin
        carry = 1'b0;
        res   = '0;
        for (int unsigned k = 0; k < NSTG; k++) begin
            carry = cy_in[k];
            res   = r_in[k];
            for (int unsigned j = 0; j < NBLK; j++) begin
                if (j / BLKS_PER_STG == k) begin
                    res[j*BLK +: BLK] = carry ? sum1[j] : sum0[j];
                    carry             = carry ? co1[j]  : co0[j];
                end
            end
            r_nxt[k]  = res;
            cy_nxt[k] = carry;
        end
    end

    // Final-stage flags (and optional clamp) computed from the fully resolved sum
    always_comb begin
        a_top = a_in[NSTG-1][WIDTH-1];
        b_top = b_in[NSTG-1][WIDTH-1];
        s_fin = r_nxt[NSTG-1];
        v_nxt = (a_top == b_top) && (s_fin[WIDTH-1] != a_top);
`ifdef PCSA_SATURATE_EN
        if (sat_in[NSTG-1] && v_nxt) begin
            s_fin = a_top ? SAT_MIN : SAT_MAX;
        end
`endif
        z_nxt = ~|s_fin;
    end

    // Stage register bank: everything loads together on adv, holds otherwise
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NSTG; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                r_q[k]   <= '0;
                cy_q[k]  <= 1'b0;
            end
            v_q <= 1'b0;
            z_q <= 1'b0;
        end else if (adv) begin
            vld_q[0] <= in_valid;
            for (int unsigned k = 1; k < NSTG; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            for (int unsigned k = 0; k < NSTG; k++) begin
                a_q[k]  <= a_in[k];
                b_q[k]  <= b_in[k];
                cy_q[k] <= cy_nxt[k];
                r_q[k]  <= (k == NSTG - 1) ? s_fin : r_nxt[k];
            end
            v_q <= v_nxt;
            z_q <= z_nxt;
        end
    end

`ifdef PCSA_SATURATE_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NSTG; k++) sat_q[k] <= 1'b0;
        end else if (adv) begin
            for (int unsigned k = 0; k < NSTG; k++) sat_q[k] <= sat_in[k];
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Bench for pipelined_csel_adder: default 32/4/2 instance (NSTG = 4) driven
// through a scoreboard, plus a 16/2/3 instance (NSTG = 3) with directed beats.
module tb_pipelined_csel_adder;

    localparam int unsigned NSTG   = 4;
    localparam int unsigned NSTG16 = 3;

    logic        clock;
    logic        reset_n;
    logic        in_valid, in_ready, sub, c_in, out_valid, out_ready, c, v, z;
    logic [31:0] in1, in2, s;
    logic        sat;

    logic        iv16, ir16, ov16, c16, v16, z16;
    logic [15:0] a16, b16, s16;
    logic        sat16;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] s;
        logic        c, v, z;
        int          acc;
        bit          lat;
    } exp_t;

    typedef struct {
        logic [31:0] a, b;
        logic        sub, cin;
        logic [31:0] s;
        logic        c, v, z;
    } vec_t;

    exp_t        sb[$];
    exp_t        cur_exp;
    exp_t        mon_e;
    bit          lat_mode;
    bit          stall_prev;
    logic [31:0] held_s;
    logic        held_c, held_v, held_z;
    vec_t        tbl[10];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    pipelined_csel_adder dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sub      (sub),
        .c_in     (c_in),
        .in1      (in1),
        .in2      (in2),
`ifdef PCSA_SATURATE_EN
        .sat      (sat),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .c        (c),
        .v        (v),
        .z        (z)
    );

    pipelined_csel_adder #(.WIDTH(16), .BLK(2), .BLKS_PER_STG(3)) dut16 (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (iv16),
        .in_ready (ir16),
        .sub      (1'b0),
        .c_in     (1'b0),
        .in1      (a16),
        .in2      (b16),
`ifdef PCSA_SATURATE_EN
        .sat      (sat16),
`endif
        .out_valid(ov16),
        .out_ready(1'b1),
        .s        (s16),
        .c        (c16),
        .v        (v16),
        .z        (z16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Reference: plain 33-bit add of the prepared operands
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sb_sub,
                                   input logic cin, input logic sb_sat);
        exp_t        e;
        logic [31:0] bb;
        logic [32:0] t;
        bb  = sb_sub ? ~b : b;
        t   = {1'b0, a} + {1'b0, bb} + 33'(sb_sub ? 1'b1 : cin);
        e.s = t[31:0];
        e.c = t[32];
        e.v = (a[31] == bb[31]) && (e.s[31] != a[31]);
        if (sb_sat && e.v) e.s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        e.z = (e.s == 32'h0);
        e.acc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] es, input logic ec, input logic ev, input logic ez);
        exp_t e;
        e.s = es; e.c = ec; e.v = ev; e.z = ez; e.acc = 0; e.lat = 1'b0;
        return e;
    endfunction

    // Monitor: push on input handshake, pop/compare on output handshake, watch stalls
    always @(negedge clock) begin
        cyc++;
        if (reset_n) begin
            if (in_valid && in_ready) begin
                mon_e     = cur_exp;
                mon_e.acc = cyc;
                mon_e.lat = lat_mode;
                sb.push_back(mon_e);
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 64'(in_ready), 64'(0));
                if (stall_prev) begin
                    check("stall_s", 64'(s), 64'(held_s));
                    check("stall_cvz", 64'({c, v, z}), 64'({held_c, held_v, held_z}));
                end
                held_s = s; held_c = c; held_v = v; held_z = z;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got s=%0h want no beat", s);
                end else begin
                    mon_e = sb.pop_front();
                    check("s", 64'(s), 64'(mon_e.s));
                    check("c", 64'(c), 64'(mon_e.c));
                    check("v", 64'(v), 64'(mon_e.v));
                    check("z", 64'(z), 64'(mon_e.z));
                    if (mon_e.lat) check("latency", 64'(cyc - mon_e.acc), 64'(NSTG));
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op_sub,
                        input logic cin, input logic op_sat, input exp_t e);
        int n;
        @(posedge clock); #1;
        in_valid = 1'b1;
        in1 = a; in2 = b; sub = op_sub; c_in = cin; sat = op_sat;
        cur_exp = e;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'(1));
    endtask

    task automatic idle();
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        check("drain", 64'(sb.size()), 64'(0));
    endtask

    task automatic t16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] es,
                       input logic ec, input logic ev, input logic ez);
        @(posedge clock); #1;
        iv16 = 1'b1; a16 = a; b16 = b;
        @(posedge clock); #1;
        iv16 = 1'b0;
        for (int k = 1; k < int'(NSTG16); k++) begin
            @(negedge clock);
            check("w16_early", 64'(ov16), 64'(0));
            @(posedge clock);
        end
        @(negedge clock);
        check("w16_valid", 64'(ov16), 64'(1));
        check("w16_s", 64'(s16), 64'(es));
        check("w16_cvz", 64'({c16, v16, z16}), 64'({ec, ev, ez}));
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; c_in = 1'b0; sat = 1'b0;
        in1 = '0; in2 = '0; lat_mode = 1'b1; stall_prev = 1'b0;
        iv16 = 1'b0; a16 = '0; b16 = '0; sat16 = 1'b0;
        cur_exp = mk(32'h0, 1'b0, 1'b0, 1'b0);
        held_s = '0; held_c = 1'b0; held_v = 1'b0; held_z = 1'b0;

        tbl[0] = '{a:32'h0000_0005, b:32'h0000_0003, sub:0, cin:1, s:32'h0000_0009, c:0, v:0, z:0};
        tbl[1] = '{a:32'hFFFF_FFFF, b:32'h0000_0001, sub:0, cin:0, s:32'h0000_0000, c:1, v:0, z:1};
        tbl[2] = '{a:32'h7FFF_FFFF, b:32'h0000_0001, sub:0, cin:0, s:32'h8000_0000, c:0, v:1, z:0};
        tbl[3] = '{a:32'h0000_0003, b:32'h0000_0005, sub:1, cin:0, s:32'hFFFF_FFFE, c:0, v:0, z:0};
        tbl[4] = '{a:32'h8000_0000, b:32'h0000_0001, sub:1, cin:0, s:32'h7FFF_FFFF, c:1, v:1, z:0};
        tbl[5] = '{a:32'h0FFF_FFFF, b:32'h0000_0001, sub:0, cin:0, s:32'h1000_0000, c:0, v:0, z:0};
        tbl[6] = '{a:32'h0000_0005, b:32'h0000_0005, sub:1, cin:1, s:32'h0000_0000, c:1, v:0, z:1};
        tbl[7] = '{a:32'h0000_0000, b:32'h0000_0000, sub:0, cin:1, s:32'h0000_0001, c:0, v:0, z:0};
        tbl[8] = '{a:32'h8000_0000, b:32'h8000_0000, sub:0, cin:0, s:32'h0000_0000, c:1, v:1, z:1};
        tbl[9] = '{a:32'h0000_FFFF, b:32'h0000_0001, sub:0, cin:1, s:32'h0001_0001, c:0, v:0, z:0};

        // Reset and idle state
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_s", 64'(s), 64'(0));
        check("rst_cvz", 64'({c, v, z}), 64'(0));
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_out_valid", 64'(out_valid), 64'(0));
        check("idle_in_ready", 64'(in_ready), 64'(1));

        // Directed table, back to back, latency checked
        lat_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, 1'b0,
                 mk(tbl[i].s, tbl[i].c, tbl[i].v, tbl[i].z));
        end
        idle();
        drain();

        // Backpressure: 10 random beats with a 5-cycle out_ready hold mid-stream
        lat_mode = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    logic [31:0] ra, rb;
                    logic        rs, rc;
                    ra = $urandom; rb = $urandom;
                    rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
                    send(ra, rb, rs, rc, 1'b0, model(ra, rb, rs, rc, 1'b0));
                end
                idle();
            end
            begin
                repeat (4) @(posedge clock);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight: none of them may emerge
        lat_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(32'h100 + 32'(i), 32'h1, 1'b0, 1'b0, 1'b0, model(32'h100 + 32'(i), 32'h1, 1'b0, 1'b0, 1'b0));
        end
        idle();
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        for (int i = 0; i < int'(NSTG) + 2; i++) begin
            @(negedge clock);
            check("postrst_no_beat", 64'(out_valid), 64'(0));
        end
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, mk(32'h2345_6789, 1'b0, 1'b0, 1'b0));
        idle();
        drain();

`ifdef PCSA_SATURATE_EN
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0));
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, mk(32'h8000_0000, 1'b1, 1'b1, 1'b0));
        send(32'h8000_0000, 32'h1, 1'b1, 1'b0, 1'b1, mk(32'h8000_0000, 1'b1, 1'b1, 1'b0));
        idle();
        drain();
`endif

        // Narrow configuration: 16-bit, 2-bit blocks, 3 blocks per stage
        check("w16_idle_ready", 64'(ir16), 64'(1));
        t16(16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0, 1'b0);
        t16(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
        t16(16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        t16(16'h5555, 16'h2AAB, 16'h8000, 1'b0, 1'b1, 1'b0);

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
